// File: rtl/line_cmd_sequencer.sv
// rtl/line_cmd_sequencer.sv - line command FIFO and sequencer feeding a Bresenham drawer
module line_cmd_sequencer #(
    parameter int COLOR_W    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [10:0]        cmd_x0,
    input  logic [10:0]        cmd_y0,
    input  logic [10:0]        cmd_x1,
    input  logic [10:0]        cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [10:0]        ld_x0,
    output logic [10:0]        ld_y0,
    output logic [10:0]        ld_x1,
    output logic [10:0]        ld_y1,
    output logic               ld_reset,
    input  logic [10:0]        ld_x,
    input  logic [10:0]        ld_y,
    output logic               pix_we,
    output logic [10:0]        pix_x,
    output logic [10:0]        pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               line_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 44 + COLOR_W;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [EW-1:0]      r_fifo [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [10:0]        r_ld_x0, r_ld_y0, r_ld_x1, r_ld_y1;
    logic [COLOR_W-1:0] r_color;
    logic [11:0]        r_remaining;
    logic               r_ld_reset;
    logic               r_line_done;

    logic               w_full, w_empty, w_push, w_pop;
    logic [EW-1:0]      w_head;
    logic [10:0]        w_hx0, w_hy0, w_hx1, w_hy1;
    logic [COLOR_W-1:0] w_hcolor;
    logic [10:0]        w_dx, w_dy, w_span;
    logic               w_last;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_head    = r_fifo[r_rd_ptr];
    assign {w_hx0, w_hy0, w_hx1, w_hy1, w_hcolor} = w_head;
    assign w_last    = (r_state == S_DRAW) && (r_remaining == 12'd0);

    // N-1 = max(|dx|,|dy|), so the down-counter ends on the last pixel
    assign w_dx   = (w_hx1 >= w_hx0) ? (w_hx1 - w_hx0) : (w_hx0 - w_hx1);
    assign w_dy   = (w_hy1 >= w_hy0) ? (w_hy1 - w_hy0) : (w_hy0 - w_hy1);
    assign w_span = (w_dx >= w_dy) ? w_dx : w_dy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: w_state_next = S_DRAW;
            S_DRAW: begin
                if (r_remaining == 12'd0) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_LOAD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_x0     <= '0;
            r_ld_y0     <= '0;
            r_ld_x1     <= '0;
            r_ld_y1     <= '0;
            r_color     <= '0;
            r_remaining <= '0;
            r_ld_reset  <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_ld_reset  <= w_pop;
            r_line_done <= w_last;
            if (w_pop) begin
                r_ld_x0     <= w_hx0;
                r_ld_y0     <= w_hy0;
                r_ld_x1     <= w_hx1;
                r_ld_y1     <= w_hy1;
                r_color     <= w_hcolor;
                r_remaining <= {1'b0, w_span};
            end else if (r_state == S_DRAW && r_remaining != 12'd0) begin
                r_remaining <= r_remaining - 12'd1;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign ld_x0     = r_ld_x0;
    assign ld_y0     = r_ld_y0;
    assign ld_x1     = r_ld_x1;
    assign ld_y1     = r_ld_y1;
    assign ld_reset  = r_ld_reset;
    assign pix_we    = (r_state == S_DRAW);
    assign pix_x     = ld_x;
    assign pix_y     = ld_y;
    assign pix_color = r_color;
    assign busy      = (r_state != S_IDLE);
    assign line_done = r_line_done;
endmodule

// File: tb/tb_line_cmd_sequencer.sv
// tb/tb_line_cmd_sequencer.sv - directed bench for line_cmd_sequencer with a Bresenham drawer model
module tb_line_cmd_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [0:0]  cmd_color = '0;
    logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
    logic        ld_reset;
    logic [10:0] ld_x, ld_y;
    logic        pix_we;
    logic [10:0] pix_x, pix_y;
    logic [0:0]  pix_color;
    logic        busy, line_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    line_cmd_sequencer #(.COLOR_W(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_reset(ld_reset), .ld_x(ld_x), .ld_y(ld_y),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .line_done(line_done)
    );

    // Drawer model: walks the major axis upward, so steep or reversed lines come out swapped
    int  m_a = 0, m_b = 0, m_err = 0, m_da = 0, m_db = 0, m_bstep = 1;
    bit  m_steep = 1'b0;
    int  d_a0, d_a1, d_b0, d_b1, d_t, d_dx, d_dy;
    always @(posedge clk) begin
        if (ld_reset) begin
            d_dx = (ld_x1 >= ld_x0) ? int'(ld_x1 - ld_x0) : int'(ld_x0 - ld_x1);
            d_dy = (ld_y1 >= ld_y0) ? int'(ld_y1 - ld_y0) : int'(ld_y0 - ld_y1);
            if (d_dy > d_dx) begin
                d_a0 = ld_y0; d_a1 = ld_y1; d_b0 = ld_x0; d_b1 = ld_x1;
            end else begin
                d_a0 = ld_x0; d_a1 = ld_x1; d_b0 = ld_y0; d_b1 = ld_y1;
            end
            if (d_a0 > d_a1) begin
                d_t = d_a0; d_a0 = d_a1; d_a1 = d_t;
                d_t = d_b0; d_b0 = d_b1; d_b1 = d_t;
            end
            m_steep <= (d_dy > d_dx);
            m_a     <= d_a0;
            m_b     <= d_b0;
            m_da    <= d_a1 - d_a0;
            m_db    <= (d_b1 >= d_b0) ? d_b1 - d_b0 : d_b0 - d_b1;
            m_bstep <= (d_b0 <= d_b1) ? 1 : -1;
            m_err   <= (d_a1 - d_a0) / 2;
        end else begin
            m_a <= m_a + 1;
            if (m_err - m_db < 0) begin
                m_b   <= m_b + m_bstep;
                m_err <= m_err - m_db + m_da;
            end else begin
                m_err <= m_err - m_db;
            end
        end
    end
    assign ld_x = m_steep ? 11'(m_b) : 11'(m_a);
    assign ld_y = m_steep ? 11'(m_a) : 11'(m_b);

    int cyc = 0;
    int qx[$], qy[$], qc[$], qt[$];
    int done_cnt = 0, done_cyc = 0, ldr_cnt = 0, rdy_low = 0, overlap = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_we) begin
                qx.push_back(int'(pix_x));
                qy.push_back(int'(pix_y));
                qc.push_back(int'(pix_color));
                qt.push_back(cyc);
            end
            if (line_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (pix_we) overlap++;
            end
            if (ld_reset) ldr_cnt++;
            if (!cmd_ready) rdy_low++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        qx.delete(); qy.delete(); qc.delete(); qt.delete();
        done_cnt = 0; done_cyc = 0; ldr_cnt = 0; rdy_low = 0; overlap = 0;
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input int c, output int acc);
        int g = 0;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = 1'(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("send_timeout", g < 5000, 1);
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        chk("idle_timeout", n < limit, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, g, errs;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_pix_we", pix_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_ld_reset", ld_reset, 0);
        chk("rst_ld_ends", {ld_x0, ld_y0, ld_x1, ld_y1}, 0);
        reset = 1'b0;
        clear_log();

        // 1: horizontal line, latency and single ld_reset pulse
        send(0, 0, 3, 0, 1, acc);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("t1_npix", qx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_x", qx[i], i);
            chk("t1_y", qy[i], 0);
            chk("t1_c", qc[i], 1);
            chk("t1_cyc", qt[i], acc + 3 + i);
        end
        chk("t1_ld_reset_cnt", ldr_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_cyc", done_cyc, acc + 7);
        chk("t1_busy", busy, 0);
        chk("t1_ld_x1", ld_x1, 3);

        // 2: vertical line given end-first
        clear_log();
        send(0, 3, 0, 0, 0, acc);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("t2_npix", qx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_x", qx[i], 0);
            chk("t2_y", qy[i], i);
            chk("t2_c", qc[i], 0);
        end
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_pix_we_held", pix_we, 0);

        // 3: degenerate point
        clear_log();
        send(7, 7, 7, 7, 1, acc);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("t3_npix", qx.size(), 1);
        chk("t3_xy", {qx[0], qy[0]}, {32'd7, 32'd7});
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_done_cyc", done_cyc, qt[0] + 1);

        // 4: five back-to-back commands overfill a 4-deep FIFO
        clear_log();
        for (int k = 0; k < 5; k++) send(0, k, 3, k, k % 2, acc);
        cmd_valid = 1'b0;
        wait_idle(500);
        chk("t4_ready_dropped", rdy_low > 0, 1);
        chk("t4_npix", qx.size(), 20);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (qx[i] != i % 4 || qy[i] != i / 4 || qc[i] != (i / 4) % 2) errs++;
        end
        chk("t4_pixel_order", errs, 0);
        for (int k = 1; k < 5; k++) chk("t4_load_gap", qt[4 * k], qt[4 * k - 1] + 2);
        chk("t4_done_cnt", done_cnt, 5);
        chk("t4_ld_reset_cnt", ldr_cnt, 5);
        chk("t4_overlap", overlap, 0);
        chk("t4_ld_y0", ld_y0, 4);

        // 5: reset on the second pixel with two lines queued
        clear_log();
        send(0, 0, 9, 0, 1, acc);
        send(0, 1, 9, 1, 0, acc);
        send(0, 2, 9, 2, 1, acc);
        cmd_valid = 1'b0;
        g = 0;
        while (!(pix_we && pix_x == 11'd1) && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("t5_reach_pix2", g < 100, 1);
        reset = 1'b1;
        #1;
        chk("t5_async_pix_we", pix_we, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (30) @(negedge clk);
        #1;
        chk("t5_no_pix", qx.size(), 0);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_no_load", ldr_cnt, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ld_x1", ld_x1, 0);

        // 6: longest horizontal span
        clear_log();
        send(0, 0, 2047, 5, 1, acc);
        cmd_valid = 1'b0;
        wait_idle(5000);
        chk("t6_npix", qx.size(), 2048);
        chk("t6_first", {qx[0], qy[0]}, 64'd0);
        chk("t6_last", {qx[2047], qy[2047]}, {32'd2047, 32'd5});
        errs = 0;
        for (int i = 0; i < qt.size(); i++) if (qt[i] != qt[0] + i) errs++;
        chk("t6_contiguous", errs, 0);
        chk("t6_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
